qam_symbol_scheduler: RTL and testbench

QAM_SYMBOL_SCHEDULER -- requirements
Module: qam_symbol_scheduler

---
 rtl/qam_symbol_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_qam_symbol_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam_symbol_scheduler.sv
// qam_symbol_scheduler: packs serial bits into 2-bit QAM symbols, buffers them
// in a small FIFO and releases one symbol every 2^PHASE_W carrier samples,
// stepping the sin/cos ROM address while a symbol is being modulated.
// Optional build macro: QAM_UNDERFLOW_CNT_EN adds a saturating underflow counter.
module qam_symbol_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int PHASE_W    = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        bit_in,
  input  logic                        bit_valid,
  output logic                        bit_ready,
  output logic [1:0]                  sym_out,
  output logic                        sym_load,
  output logic [PHASE_W-1:0]          rom_addr,
  output logic                        active,
  output logic [1:0]                  state,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        underflow,
  output logic [7:0]                  underflow_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [PHASE_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PRIME = 2'b01,
    RUN   = 2'b10,
    DRAIN = 2'b11
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PHASE_W-1:0]   r_rom_addr;
  logic [PHASE_W-1:0]   w_rom_addr_nxt;
  logic [1:0]           r_sym_out;
  logic [1:0]           w_sym_nxt;
  logic                 r_sym_load;
  logic                 w_sym_load_nxt;
  logic                 r_underflow;
  logic                 w_underflow_nxt;
  logic                 w_pop;

  logic                 r_pair_half;
  logic                 r_first_bit;
  logic                 w_accept;
  logic                 w_push;

  logic [1:0]           r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [1:0]           w_head;
  logic                 w_empty;
  logic                 w_at_end;

  // A first bit is always taken; the completing bit needs a free FIFO slot
  // judged on pre-pop occupancy (no bypass).
  assign bit_ready = (r_count < FULL_CNT) || !r_pair_half;
  assign w_accept  = bit_valid && bit_ready;
  assign w_push    = w_accept && r_pair_half;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_empty   = (r_count == '0);
  assign w_at_end  = (r_rom_addr == LAST_ADDR);

  // Bit-pair packer: first bit of a pair is held until its partner arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pair_half <= 1'b0;
      r_first_bit <= 1'b0;
    end else if (w_accept) begin
      if (!r_pair_half) begin
        r_first_bit <= bit_in;
        r_pair_half <= 1'b1;
      end else begin
        r_pair_half <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset since pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_first_bit, bit_in};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_rom_addr  <= '0;
      r_sym_out   <= 2'b00;
      r_sym_load  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rom_addr  <= w_rom_addr_nxt;
      r_sym_out   <= w_sym_nxt;
      r_sym_load  <= w_sym_load_nxt;
      r_underflow <= w_underflow_nxt;
    end
  end

  // Next-state logic. RUN and DRAIN share one branch: enable alone decides
  // whether the symbol boundary reloads (RUN) or ends the burst (IDLE).
  always_comb begin
    w_state_nxt     = r_state;
    w_rom_addr_nxt  = r_rom_addr;
    w_sym_nxt       = r_sym_out;
    w_sym_load_nxt  = 1'b0;
    w_underflow_nxt = 1'b0;
    w_pop           = 1'b0;
    case (r_state)
      IDLE: begin
        w_rom_addr_nxt = '0;
        if (enable) w_state_nxt = PRIME;
      end
      PRIME: begin
        w_rom_addr_nxt = '0;
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (!w_empty) begin
          w_state_nxt    = RUN;
          w_sym_load_nxt = 1'b1;
          w_pop          = 1'b1;
          w_sym_nxt      = w_head;
        end
      end
      RUN, DRAIN: begin
        if (w_at_end) begin
          w_rom_addr_nxt = '0;
          if (enable) begin
            w_state_nxt    = RUN;
            w_sym_load_nxt = 1'b1;
            if (!w_empty) begin
              w_pop     = 1'b1;
              w_sym_nxt = w_head;
            end else begin
              w_sym_nxt       = 2'b00;
              w_underflow_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_rom_addr_nxt = r_rom_addr + 1'b1;
          w_state_nxt    = enable ? RUN : DRAIN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef QAM_UNDERFLOW_CNT_EN
  logic [7:0] r_unf_cnt;

  // Saturating count of underflow pulses, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_unf_cnt <= '0;
    end else if (w_underflow_nxt && (r_unf_cnt != 8'hFF)) begin
      r_unf_cnt <= r_unf_cnt + 1'b1;
    end
  end

  assign underflow_cnt = r_unf_cnt;
`else
  assign underflow_cnt = '0;
`endif

  assign sym_out    = r_sym_out;
  assign sym_load   = r_sym_load;
  assign rom_addr   = r_rom_addr;
  assign active     = (r_state == RUN) || (r_state == DRAIN);
  assign state      = r_state;
  assign fifo_count = r_count;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// Self-checking bench for qam_symbol_scheduler: directed scenarios followed by
// randomized traffic, all outputs compared every cycle against a reference
// model built from a symbol queue and a sample index within the symbol.
module tb_qam_symbol_scheduler;

  localparam int DEPTH = 4;
  localparam int PW    = 7;
  localparam int SPS   = 1 << PW;
`ifdef QAM_UNDERFLOW_CNT_EN
  localparam int UCNT_ON = 1;
`else
  localparam int UCNT_ON = 0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_PRIME = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   enable;
  logic                   bit_in;
  logic                   bit_valid;
  logic                   bit_ready;
  logic [1:0]             sym_out;
  logic                   sym_load;
  logic [PW-1:0]          rom_addr;
  logic                   active;
  logic [1:0]             state;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   underflow;
  logic [7:0]             underflow_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  qam_symbol_scheduler #(.FIFO_DEPTH(DEPTH), .PHASE_W(PW)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .bit_in        (bit_in),
    .bit_valid     (bit_valid),
    .bit_ready     (bit_ready),
    .sym_out       (sym_out),
    .sym_load      (sym_load),
    .rom_addr      (rom_addr),
    .active        (active),
    .state         (state),
    .fifo_count    (fifo_count),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_q[$];
  bit m_half;
  int m_first;
  int m_mode;
  int m_idx;
  int m_sym;
  bit m_load;
  bit m_unf;
  int m_ucnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_half  = 0;
    m_first = 0;
    m_mode  = M_IDLE;
    m_idx   = 0;
    m_sym   = 0;
    m_load  = 0;
    m_unf   = 0;
    m_ucnt  = 0;
  endtask

  // One rising edge of the reference behaviour, using the inputs being driven.
  task automatic model_step();
    bit ready;
    bit take;
    int occ;
    occ   = m_q.size();
    ready = (occ < DEPTH) || !m_half;
    take  = 0;
    m_load = 0;
    m_unf  = 0;
    if (m_mode == M_IDLE) begin
      m_idx = 0;
      if (enable) m_mode = M_PRIME;
    end else if (m_mode == M_PRIME) begin
      m_idx = 0;
      if (!enable) m_mode = M_IDLE;
      else if (occ > 0) begin
        m_mode = M_RUN;
        m_load = 1;
        take   = 1;
      end
    end else begin
      m_idx = (m_idx + 1) % SPS;
      if (m_idx != 0) begin
        m_mode = enable ? M_RUN : M_DRAIN;
      end else if (!enable) begin
        m_mode = M_IDLE;
      end else begin
        m_mode = M_RUN;
        m_load = 1;
        if (occ > 0) take = 1;
        else begin
          m_sym  = 0;
          m_unf  = 1;
          m_ucnt = (m_ucnt < 255) ? m_ucnt + 1 : 255;
        end
      end
    end
    if (take) m_sym = m_q.pop_front();
    if (bit_valid && ready) begin
      if (!m_half) begin
        m_first = int'(bit_in);
        m_half  = 1;
      end else begin
        m_q.push_back(2 * m_first + int'(bit_in));
        m_half = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("bit_ready", bit_ready, ((m_q.size() < DEPTH) || !m_half) ? 1 : 0);
    chk("sym_out", sym_out, m_sym);
    chk("sym_load", sym_load, m_load);
    chk("rom_addr", rom_addr, m_idx);
    chk("active", active, (m_mode == M_RUN || m_mode == M_DRAIN) ? 1 : 0);
    chk("state", state, m_mode);
    chk("fifo_count", fifo_count, m_q.size());
    chk("underflow", underflow, m_unf);
    chk("underflow_cnt", underflow_cnt, UCNT_ON ? m_ucnt : 0);
  endtask

  task automatic cyc(input logic en, input logic v, input logic b);
    @(negedge clk);
    enable    = en;
    bit_valid = v;
    bit_in    = b;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nloads;
    int seen[2];
    bit cur_en;

    reset = 1'b0; enable = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // Basic start: pair 1,0 -> symbol 10, loaded one cycle after the push
    cyc(1, 0, 0);
    chk("req033_prime", state, 1);
    cyc(1, 1, 1);
    cyc(1, 1, 0);
    chk("req033_count", fifo_count, 1);
    cyc(1, 0, 0);
    chk("req033_load", sym_load, 1);
    chk("req033_addr", rom_addr, 0);
    chk("req033_sym", sym_out, 2);
    chk("req033_active", active, 1);

    // Stream 0,1,1,1 and watch two symbol loads over 256 samples
    nloads = 0;
    seen[0] = -1; seen[1] = -1;
    for (int i = 0; i < 256; i++) begin
      case (i)
        0: cyc(1, 1, 0);
        1, 2, 3: cyc(1, 1, 1);
        default: cyc(1, 0, 0);
      endcase
      if (sym_load === 1'b1) begin
        if (nloads < 2) seen[nloads] = int'(sym_out);
        nloads++;
      end
    end
    chk("req034_nloads", nloads, 2);
    chk("req034_sym0", seen[0], 1);
    chk("req034_sym1", seen[1], 3);
    chk("req034_count", fifo_count, 0);

    // Empty FIFO at the boundary -> underflow
    for (int i = 0; i < SPS; i++) cyc(1, 0, 0);
    chk("req035_sym", sym_out, 0);
    chk("req035_unf", underflow, 1);
    chk("req035_ucnt", underflow_cnt, UCNT_ON ? 1 : 0);

    // Fill 4 symbols plus one spare first bit; second bit blocked until a pop
    for (int i = 0; i < 9; i++) cyc(1, 1, 1'($urandom_range(0, 1)));
    chk("req036_full", fifo_count, 4);
    chk("req036_blocked", bit_ready, 0);
    for (int i = 0; i < 200 && sym_load !== 1'b1; i++) cyc(1, 1, 1'($urandom_range(0, 1)));
    chk("req036_pop_seen", sym_load, 1);
    chk("req036_after_pop", fifo_count, 3);
    chk("req036_ready", bit_ready, 1);
    cyc(1, 1, 1'($urandom_range(0, 1)));
    chk("req036_refill", fifo_count, 4);

    // Drop enable at sample 40: drain to the end of the symbol, then idle
    for (int i = 0; i < 200 && rom_addr !== 7'd40; i++) cyc(1, 0, 0);
    chk("req037_at40", rom_addr, 40);
    cyc(0, 0, 0);
    chk("req037_drain", state, 3);
    chk("req037_addr", rom_addr, 41);
    for (int i = 0; i < 200 && rom_addr !== 7'd0; i++) cyc(0, 0, 0);
    chk("req037_idle", state, 0);
    chk("req037_addr0", rom_addr, 0);
    chk("req037_noload", sym_load, 0);
    chk("req037_count", fifo_count, 4);

    // Asynchronous reset mid-symbol with three symbols queued
    for (int i = 0; i < 400 && !(state === 2'b10 && rom_addr === 7'd60); i++)
      cyc(1, (m_q.size() < 3) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
    chk("req038_count3", fifo_count, 3);
    #2;
    reset = 1'b0; enable = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("req038_count0", fifo_count, 0);
    chk("req038_ready", bit_ready, 1);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic with occasional enable toggles
    cur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) cur_en = !cur_en;
      cyc(cur_en, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Starve the FIFO long enough to saturate the underflow counter
    for (int i = 0; i < 260 * SPS; i++) cyc(1, 0, 0);
    chk("sat_ucnt", underflow_cnt, UCNT_ON ? 255 : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
